// File: rtl/core_alu_reg_if.sv
// ALU bus for core_alu_reg: operation select, operands, flag mask and the
// C/V/N/Z flags going in and out. The master drives the operation; the
// slave (the ALU) returns the result and the updated flags.
interface core_alu_reg_if;
  logic [3:0] I_control;
  logic [3:0] I_mask_p;
  logic [7:0] I_lhs;
  logic [7:0] I_rhs;
  logic       I_carry;
  logic       I_overflow;
  logic       I_sign;
  logic       I_zero;
  logic [7:0] O_result;
  logic       O_carry;
  logic       O_overflow;
  logic       O_sign;
  logic       O_zero;

  modport master (
    output I_control, I_mask_p, I_lhs, I_rhs,
    output I_carry, I_overflow, I_sign, I_zero,
    input  O_result, O_carry, O_overflow, O_sign, O_zero
  );

  modport slave (
    input  I_control, I_mask_p, I_lhs, I_rhs,
    input  I_carry, I_overflow, I_sign, I_zero,
    output O_result, O_carry, O_overflow, O_sign, O_zero
  );
endinterface

// File: rtl/core_alu_reg.sv
// 6502-style 8-bit ALU with per-flag update masking. Next to it sits an
// independent WIDTH-bit storage register with a load enable. The ALU is
// purely combinational and ignores clock and reset; only the register
// is clocked.
module core_alu_reg #(
  parameter int WIDTH = 8
) (
  input  logic             I_clock,
  input  logic             I_reset,
  input  logic             I_enable,
  input  logic [WIDTH-1:0] I_d,
  output logic [WIDTH-1:0] O_q,
  core_alu_reg_if.slave    alu
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADC = 4'h1,
    OP_SBC = 4'h2,
    OP_AND = 4'h3,
    OP_ORA = 4'h4,
    OP_EOR = 4'h5,
    OP_ASL = 4'h6,
    OP_LSR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_INC = 4'hA,
    OP_DEC = 4'hB,
    OP_CMP = 4'hC,
    OP_BIT = 4'hD,
    OP_LD  = 4'hE
  } alu_op_e;

  logic [7:0] lhs;
  logic [7:0] rhs;
  logic [7:0] op_b;
  logic [8:0] sum9;
  logic [7:0] res;
  logic       c_new;
  logic       v_new;
  logic       n_new;
  logic       z_new;
  logic       nz_from_res;

  assign lhs = alu.I_lhs;
  assign rhs = alu.I_rhs;

  // Compute the result and the unmasked flags for the selected operation.
  always_comb begin
    // NOTE: every variable gets a default before the case. Any path that
    // left one unassigned would infer a latch.
    op_b        = rhs;
    sum9        = '0;
    res         = lhs;
    c_new       = alu.I_carry;
    v_new       = alu.I_overflow;
    n_new       = alu.I_sign;
    z_new       = alu.I_zero;
    nz_from_res = 1'b1;
    case (alu_op_e'(alu.I_control))
      OP_ADC, OP_SBC: begin
        // SBC is ADC on the inverted operand; carry in 1 means no borrow.
        op_b  = (alu.I_control == OP_SBC) ? ~rhs : rhs;
        sum9  = {1'b0, lhs} + {1'b0, op_b} + {8'b0, alu.I_carry};
        res   = sum9[7:0];
        c_new = sum9[8];
        v_new = ~(lhs[7] ^ op_b[7]) & (lhs[7] ^ sum9[7]);
      end
      OP_AND: res = lhs & rhs;
      OP_ORA: res = lhs | rhs;
      OP_EOR: res = lhs ^ rhs;
      OP_ASL: begin
        res   = {lhs[6:0], 1'b0};
        c_new = lhs[7];
      end
      OP_LSR: begin
        res   = {1'b0, lhs[7:1]};
        c_new = lhs[0];
      end
      OP_ROL: begin
        res   = {lhs[6:0], alu.I_carry};
        c_new = lhs[7];
      end
      OP_ROR: begin
        res   = {alu.I_carry, lhs[7:1]};
        c_new = lhs[0];
      end
      OP_INC: res = lhs + 8'd1;
      OP_DEC: res = lhs - 8'd1;
      OP_CMP: begin
        // lhs + ~rhs + 1 == lhs - rhs; the carry out is set when no borrow occurs.
        sum9  = {1'b0, lhs} + {1'b0, ~rhs} + 9'd1;
        res   = sum9[7:0];
        c_new = sum9[8];
      end
      OP_BIT: begin
        res         = lhs;
        z_new       = ((lhs & rhs) == 8'h00);
        n_new       = rhs[7];
        v_new       = rhs[6];
        nz_from_res = 1'b0;
      end
      OP_LD: res = rhs;
      default: nz_from_res = 1'b0;  // NOP and the reserved code 0xF
    endcase
    if (nz_from_res) begin
      n_new = res[7];
      z_new = (res == 8'h00);
    end
  end

  // A flag takes its computed value only where its mask bit is set.
  // The result itself is never masked.
  assign alu.O_result   = res;
  assign alu.O_sign     = alu.I_mask_p[3] ? n_new : alu.I_sign;
  assign alu.O_overflow = alu.I_mask_p[2] ? v_new : alu.I_overflow;
  assign alu.O_zero     = alu.I_mask_p[1] ? z_new : alu.I_zero;
  assign alu.O_carry    = alu.I_mask_p[0] ? c_new : alu.I_carry;

  // Storage register: asynchronous clear, load on enable, hold otherwise.
  always_ff @(posedge I_clock or negedge I_reset) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops
    // update together at the edge.
    if (!I_reset) begin
      O_q <= '0;
    end else if (I_enable) begin
      O_q <= I_d;
    end
  end

endmodule

// File: tb/tb_core_alu_reg.sv
// Self-checking bench for core_alu_reg. It runs directed ALU vectors
// with hand-derived expectations, then random ALU vectors checked
// against an arithmetic reference model. It also checks the WIDTH=16
// register through reset, load, hold and a mid-cycle asynchronous clear.
module tb_core_alu_reg;
  localparam int WIDTH = 16;

  logic             I_clock = 1'b0;
  logic             I_reset;
  logic             I_enable;
  logic [WIDTH-1:0] I_d;
  logic [WIDTH-1:0] O_q;

  int checks = 0;
  int errors = 0;

  core_alu_reg_if alu ();

  core_alu_reg #(.WIDTH(WIDTH)) dut (
    .I_clock  (I_clock),
    .I_reset  (I_reset),
    .I_enable (I_enable),
    .I_d      (I_d),
    .O_q      (O_q),
    .alu      (alu)
  );

  always #5 I_clock = ~I_clock;

  // Watchdog so the run always ends, even if the sequence stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built from arithmetic on plain integers.
  // It returns {result[7:0], N, V, Z, C} after masking.
  function automatic logic [11:0] model(input int op, input int a, input int b,
                                        input logic [3:0] fin, input logic [3:0] mask);
    int  r, s, sa, sb, ci;
    bit  n, v, z, c, nz;
    ci = int'(fin[0]);
    n  = fin[3]; v = fin[2]; z = fin[1]; c = fin[0];
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r  = a;
    nz = 1'b1;
    case (op)
      1: begin
        s = a + b + ci; r = s % 256; c = (s > 255);
        s = sa + sb + ci; v = (s > 127) || (s < -128);
      end
      2: begin
        s = a - b - (1 - ci); r = (s + 256) % 256; c = (s >= 0);
        s = sa - sb - (1 - ci); v = (s > 127) || (s < -128);
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin r = (a * 2) % 256; c = (a >= 128); end
      7: begin r = a / 2; c = ((a % 2) == 1); end
      8: begin r = (a * 2) % 256 + ci; c = (a >= 128); end
      9: begin r = a / 2 + 128 * ci; c = ((a % 2) == 1); end
      10: r = (a + 1) % 256;
      11: r = (a + 255) % 256;
      12: begin r = (a - b + 256) % 256; c = (a >= b); end
      13: begin z = ((a & b) == 0); n = (b >= 128); v = (((b / 64) % 2) == 1); nz = 1'b0; end
      14: r = b;
      default: nz = 1'b0;
    endcase
    if (nz) begin
      n = (r >= 128);
      z = (r == 0);
    end
    if (!mask[3]) n = fin[3];
    if (!mask[2]) v = fin[2];
    if (!mask[1]) z = fin[1];
    if (!mask[0]) c = fin[0];
    return {r[7:0], n, v, z, c};
  endfunction

  // Drive one ALU operation; fin and the returned flag nibble are ordered {N,V,Z,C}.
  task automatic drive_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] fin, input logic [3:0] mask);
    alu.I_control  = op;
    alu.I_lhs      = a;
    alu.I_rhs      = b;
    alu.I_sign     = fin[3];
    alu.I_overflow = fin[2];
    alu.I_zero     = fin[1];
    alu.I_carry    = fin[0];
    alu.I_mask_p   = mask;
    #1;
  endtask

  function automatic logic [31:0] alu_obs();
    return {20'b0, alu.O_result, alu.O_sign, alu.O_overflow, alu.O_zero, alu.O_carry};
  endfunction

  initial begin
    logic [3:0]       r_op, r_fin, r_mask;
    logic [7:0]       r_a, r_b;
    logic [WIDTH-1:0] q_exp;

    I_reset  = 1'b0;
    I_enable = 1'b0;
    I_d      = '0;
    drive_alu(4'h0, 8'h00, 8'h00, 4'h0, 4'h0);
    #1;
    check("reset_q", 32'(O_q), 32'h0);

    // Directed ALU vectors with hand-derived expectations ({result, NVZC}).
    drive_alu(4'h1, 8'h50, 8'h50, 4'b0000, 4'hF); check("adc_50_50",   alu_obs(), {20'b0, 8'hA0, 4'b1100});
    drive_alu(4'h1, 8'hFF, 8'h01, 4'b0000, 4'hF); check("adc_ff_01",   alu_obs(), {20'b0, 8'h00, 4'b0011});
    drive_alu(4'h2, 8'h00, 8'h01, 4'b0001, 4'hF); check("sbc_00_01",   alu_obs(), {20'b0, 8'hFF, 4'b1000});
    drive_alu(4'hC, 8'h10, 8'h10, 4'b0000, 4'hF); check("cmp_eq",      alu_obs(), {20'b0, 8'h00, 4'b0011});
    drive_alu(4'hC, 8'h0F, 8'h10, 4'b0000, 4'hF); check("cmp_lt",      alu_obs(), {20'b0, 8'hFF, 4'b1000});
    drive_alu(4'h9, 8'h01, 8'h00, 4'b0001, 4'hF); check("ror_01_c1",   alu_obs(), {20'b0, 8'h80, 4'b1001});
    drive_alu(4'hD, 8'h0F, 8'hC0, 4'b0000, 4'hF); check("bit_0f_c0",   alu_obs(), {20'b0, 8'h0F, 4'b1110});
    drive_alu(4'h1, 8'hFF, 8'h01, 4'b1000, 4'h0); check("adc_masked",  alu_obs(), {20'b0, 8'h00, 4'b1000});
    drive_alu(4'h0, 8'h3C, 8'h99, 4'b1010, 4'hF); check("nop_pass",    alu_obs(), {20'b0, 8'h3C, 4'b1010});
    drive_alu(4'hF, 8'h3C, 8'h99, 4'b0101, 4'hF); check("rsvd_pass",   alu_obs(), {20'b0, 8'h3C, 4'b0101});
    drive_alu(4'hA, 8'hFF, 8'h00, 4'b0101, 4'hF); check("inc_wrap",    alu_obs(), {20'b0, 8'h00, 4'b0111});
    drive_alu(4'hB, 8'h00, 8'h00, 4'b0000, 4'hF); check("dec_wrap",    alu_obs(), {20'b0, 8'hFF, 4'b1000});
    drive_alu(4'h7, 8'h81, 8'h00, 4'b1000, 4'hF); check("lsr_81",      alu_obs(), {20'b0, 8'h40, 4'b0001});
    drive_alu(4'h8, 8'h80, 8'h00, 4'b0001, 4'hF); check("rol_80_c1",   alu_obs(), {20'b0, 8'h01, 4'b0001});
    drive_alu(4'hE, 8'h12, 8'h80, 4'b0101, 4'hA); check("ld_80_mask",  alu_obs(), {20'b0, 8'h80, 4'b1101});

    // Random ALU vectors against the reference model.
    for (int i = 0; i < 300; i++) begin
      r_op   = 4'($urandom_range(0, 15));
      r_a    = 8'($urandom);
      r_b    = 8'($urandom);
      r_fin  = 4'($urandom);
      r_mask = 4'($urandom);
      drive_alu(r_op, r_a, r_b, r_fin, r_mask);
      check($sformatf("rand_alu_op%0h", r_op), alu_obs(),
            {20'b0, model(int'(r_op), int'(r_a), int'(r_b), r_fin, r_mask)});
    end

    // An edge with enable set while reset is held must not load.
    @(negedge I_clock);
    I_enable = 1'b1;
    I_d      = 16'hAAAA;
    @(posedge I_clock); #1;
    check("hold_in_reset", 32'(O_q), 32'h0);

    @(negedge I_clock);
    I_reset  = 1'b1;
    I_enable = 1'b1;
    I_d      = 16'hBEEF;
    @(posedge I_clock); #1;
    check("load_beef", 32'(O_q), 32'hBEEF);

    @(negedge I_clock);
    I_enable = 1'b0;
    I_d      = 16'h1234;
    @(posedge I_clock); #1;
    check("hold_beef", 32'(O_q), 32'hBEEF);

    // Asynchronous clear between edges.
    #2;
    I_reset = 1'b0;
    #1;
    check("async_clear", 32'(O_q), 32'h0);

    // The ALU must keep working while the register is held in reset.
    drive_alu(4'h1, 8'h50, 8'h50, 4'b0000, 4'hF);
    check("alu_in_reset", alu_obs(), {20'b0, 8'hA0, 4'b1100});

    @(negedge I_clock);
    I_enable = 1'b1;
    I_d      = 16'h5555;
    @(posedge I_clock); #1;
    check("still_reset", 32'(O_q), 32'h0);

    @(negedge I_clock);
    I_reset = 1'b1;
    @(posedge I_clock); #1;
    check("first_load", 32'(O_q), 32'h5555);

    // Random enable/data against a simple register model.
    q_exp = 16'h5555;
    for (int i = 0; i < 40; i++) begin
      @(negedge I_clock);
      I_enable = 1'($urandom);
      I_d      = 16'($urandom);
      if (I_enable) q_exp = I_d;
      @(posedge I_clock); #1;
      check("rand_reg", 32'(O_q), 32'(q_exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_alu_reg.md
CORE_ALU_REG -- requirements
Module: core_alu_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of the storage register (D/Q ports).
REQ-002 SHALL have port I_clock, input, 1, clock; register samples on rising edge.
REQ-003 SHALL have port I_reset, input, 1, reset: asynchronous, active-low; clock I_clock.
REQ-004 SHALL have port I_enable, input, 1, register load enable.
REQ-005 SHALL have port I_d, input, WIDTH, register data in.
REQ-006 SHALL have port O_q, output, WIDTH, register data out.
REQ-007 SHALL have port I_control, input, 4, ALU operation select (encoding per REQ-013..REQ-027).
REQ-008 SHALL have port I_mask_p, input, 4, flag update mask: [3]=N, [2]=V, [1]=Z, [0]=C.
REQ-009 SHALL have ports I_lhs and I_rhs, input, 8 each, ALU operands.
REQ-010 SHALL have ports I_carry, I_overflow, I_sign, I_zero, input, 1 each, incoming C/V/N/Z flags.
REQ-011 SHALL have ports O_result (output, 8) and O_carry, O_overflow, O_sign, O_zero (output, 1 each).

Function
REQ-012 ALU SHALL be purely combinational, zero latency, independent of I_clock/I_reset.
REQ-013 0x0 NOP: result=lhs; all flags pass through unchanged.
REQ-014 0x1 ADC: sum=lhs+rhs+I_carry (9-bit); result=sum[7:0]; C=sum[8]; V=bit7 of (~(lhs^rhs) & (lhs^result)); N,Z from result.
REQ-015 0x2 SBC: as ADC with rhs replaced by ~rhs (C=1 means no borrow); no decimal mode.
REQ-016 0x3 AND, 0x4 ORA, 0x5 EOR: bitwise lhs op rhs; N,Z from result; C,V pass through.
REQ-017 0x6 ASL: result={lhs[6:0],0}; C=lhs[7]; N,Z from result.
REQ-018 0x7 LSR: result={0,lhs[7:1]}; C=lhs[0]; N=0; Z from result.
REQ-019 0x8 ROL: result={lhs[6:0],I_carry}; C=lhs[7]; N,Z from result.
REQ-020 0x9 ROR: result={I_carry,lhs[7:1]}; C=lhs[0]; N,Z from result.
REQ-021 0xA INC: result=lhs+1 mod 256 (0xFF wraps to 0x00); 0xB DEC: result=lhs-1 mod 256 (0x00 wraps to 0xFF); N,Z from result; C,V pass through.
REQ-022 0xC CMP: result=lhs-rhs mod 256; C=(lhs>=rhs unsigned); N,Z from result; V passes through.
REQ-023 0xD BIT: result=lhs; Z=((lhs&rhs)==0); N=rhs[7]; V=rhs[6]; C passes through.
REQ-024 0xE LD: result=rhs; N,Z from result; C,V pass through.
REQ-025 0xF reserved: SHALL behave identically to NOP.
REQ-026 "N,Z from result" SHALL mean N=result[7], Z=(result==0).
REQ-027 Flag masking: for each flag, output = computed value when its I_mask_p bit is 1, else the corresponding input flag; O_result is never masked.
REQ-028 Register: on rising I_clock with I_reset high and I_enable=1, O_q SHALL take I_d; with I_enable=0, O_q SHALL hold.
REQ-029 Register output SHALL change only on a clock edge or on reset; no combinational path I_d->O_q.

Reset
REQ-030 I_reset low SHALL asynchronously force O_q to 0, regardless of clock or I_enable, including mid-cycle.
REQ-031 While I_reset is low, O_q SHALL stay 0; first load SHALL occur on the first rising I_clock after release with I_enable=1.
REQ-032 ALU outputs SHALL be unaffected by I_reset.

Verification
REQ-033 ADC lhs=0x50 rhs=0x50 C=0 mask=0xF -> result 0xA0, N=1 V=1 Z=0 C=0; ADC 0xFF+0x01 C=0 -> 0x00, Z=1 C=1 V=0.
REQ-034 SBC lhs=0x00 rhs=0x01 C=1 -> 0xFF, N=1 C=0 Z=0 V=0; CMP 0x10 vs 0x10 -> Z=1 C=1 N=0; CMP 0x0F vs 0x10 -> C=0 N=1.
REQ-035 ROR lhs=0x01 C=1 -> 0x80, C=1 N=1; BIT lhs=0x0F rhs=0xC0 -> Z=1 N=1 V=1, result 0x0F.
REQ-036 ADC 0xFF+0x01 with mask=0x0 and input flags N=1 V=0 Z=0 C=0 -> result 0x00, flags out N=1 V=0 Z=0 C=0.
REQ-037 Register WIDTH=16: load 0xBEEF with enable=1 -> O_q=0xBEEF next edge; enable=0 with I_d=0x1234 -> holds 0xBEEF; assert I_reset between edges -> O_q=0x0000 immediately.
